// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: widths, NOP encoding, instruction fields and
// fetch FSM state encodings.
package cpu_defs;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] NOP_INSN = 8'hF0;

    // Instruction layout: [opcode4][rdest2][rsrc2/imm]
    localparam int OPC_HI  = 7;
    localparam int OPC_LO  = 4;
    localparam int RDST_HI = 3;
    localparam int RDST_LO = 2;
    localparam int RSRC_HI = 1;
    localparam int RSRC_LO = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    function automatic logic [3:0] opcode_of(input logic [DATA_W-1:0] insn);
        return insn[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter: redirect load beats increment. With FETCH_WRAP_HALT_EN
// defined the counter sticks at its top value instead of wrapping.
module program_counter #(
    parameter int                ADDR_W   = cpu_defs::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [ADDR_W-1:0] ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PC_TOP = {ADDR_W{1'b1}};

    logic step;

`ifdef FETCH_WRAP_HALT_EN
    assign step = inc && (pc != PC_TOP);
`else
    assign step = inc;
`endif

    // PC register: load on redirect, else step on capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    pc <= RESET_PC;
        else if (load) pc <= load_pc;
        else if (step) pc <= pc + ONE;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC as the memory address, registers
// the returned instruction into a one-entry slot with valid/ready handoff,
// handles redirects and keeps a saturating accepted-instruction count.
// Optional macro FETCH_WRAP_HALT_EN: halt after capturing at the top PC.
module fetch_unit #(
    parameter int                ADDR_W   = cpu_defs::ADDR_W,
    parameter int                DATA_W   = cpu_defs::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [DATA_W-1:0] NOP_INSN = cpu_defs::NOP_INSN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] instruction,
    output logic [DATA_W-1:0] ir_out,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [15:0]       fetch_count,
    output logic              halted
);
    import cpu_defs::*;

    fetch_state_e      state, state_nx;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       count_q;
    logic              slot_free, capture, accept;

    assign slot_free = !ir_valid || ir_ready;
    assign capture   = (state == RUN) && fetch_en && slot_free && !branch_valid;
    // A redirect flushes whatever is offered, so it is never counted.
    assign accept    = ir_valid && ir_ready && !branch_valid;

    program_counter #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (branch_valid),
        .load_pc(branch_target),
        .inc    (capture),
        .pc     (pc)
    );

    assign address     = pc;
    assign fetch_count = count_q;

`ifdef FETCH_WRAP_HALT_EN
    logic at_top;
    assign at_top = (pc == {ADDR_W{1'b1}});
    assign halted = (state == HALT);
`else
    assign halted = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // FSM next state; a redirect in IDLE only moves the PC
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (fetch_en && !branch_valid) state_nx = RUN;
            RUN: begin
                if (!fetch_en) state_nx = IDLE;
`ifdef FETCH_WRAP_HALT_EN
                else if (capture && at_top) state_nx = HALT;
            end
            HALT: if (branch_valid) state_nx = RUN;
`else
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    // Output slot: flush on redirect, load on capture, drain when consumed,
    // otherwise hold (stable while valid and not ready)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_out   <= NOP_INSN;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
        end else if (branch_valid) begin
            ir_out   <= NOP_INSN;
            ir_valid <= 1'b0;
        end else if (capture) begin
            ir_out   <= instruction;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
        end else if (ir_valid && ir_ready) begin
            ir_out   <= NOP_INSN;
            ir_valid <= 1'b0;
        end
    end

    // Saturating count of instructions taken by the decoder
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              count_q <= '0;
        else if (accept && (count_q != 16'hFFFF)) count_q <= count_q + 16'd1;
    end

endmodule
